// File: rtl/mskand_hpc2_arb_pkg.sv
// Shared constants and helpers for the two-requester HPC2 masked-AND arbiter.
package mskand_hpc2_arb_pkg;

    // Number of requesters sharing the single gadget.
    localparam int NREQ = 2;

    // Requester index carried alongside each issue.
    typedef enum logic {
        REQ_0 = 1'b0,
        REQ_1 = 1'b1
    } req_id_e;

    // Fresh random bits one HPC2 issue consumes for a given share count.
    function automatic int hpc2rnd_f(input int shares);
        return (shares * (shares - 1)) / 2;
    endfunction

    // Position of the random bit shared by share pair (i, j), i < j.
    function automatic int rnd_idx(input int i, input int j, input int shares);
        return (i * shares) - ((i * (i + 1)) / 2) + (j - i - 1);
    endfunction

endpackage

// File: rtl/mskand_hpc2_arb_gadget.sv
// HPC2 masked AND gadget: inb and rnd sampled in cycle T, ina in T+1,
// product sharing visible in T+2. Pair (i,j) shares one random bit r_ij = r_ji.
module mskand_hpc2_arb_gadget
    import mskand_hpc2_arb_pkg::*;
#(
    parameter int d       = 2,
    parameter int hpc2rnd = hpc2rnd_f(d)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [d-1:0]       ina,
    input  logic [d-1:0]       inb,
    input  logic [hpc2rnd-1:0] rnd,
    output logic [d-1:0]       res
);

    for (genvar i = 0; i < d; i++) begin : g_share
        logic [d-1:0] r_s;
        logic [d-1:0] br_s;
        logic         b_q;
        logic [d-1:0] r_q;
        logic [d-1:0] br_q;
        logic         ab_q;
        logic [d-1:0] nar_q;
        logic [d-1:0] abr_q;

        for (genvar j = 0; j < d; j++) begin : g_pair
            if (j == i) begin : g_diag
                assign r_s[j]  = 1'b0;
                assign br_s[j] = 1'b0;
            end else if (i < j) begin : g_upper
                assign r_s[j]  = rnd[rnd_idx(i, j, d)];
                assign br_s[j] = inb[j] ^ r_s[j];
            end else begin : g_lower
                assign r_s[j]  = rnd[rnd_idx(j, i, d)];
                assign br_s[j] = inb[j] ^ r_s[j];
            end
        end

        // Two register layers: first isolates b/r, second the partial products with a.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                b_q   <= 1'b0;
                r_q   <= '0;
                br_q  <= '0;
                ab_q  <= 1'b0;
                nar_q <= '0;
                abr_q <= '0;
            end else begin
                b_q   <= inb[i];
                r_q   <= r_s;
                br_q  <= br_s;
                ab_q  <= ina[i] & b_q;
                nar_q <= {d{~ina[i]}} & r_q;
                abr_q <= {d{ina[i]}} & br_q;
            end
        end

        // Diagonal terms are zero, so full-width XOR reduction is safe.
        assign res[i] = ab_q ^ (^nar_q) ^ (^abr_q);
    end

endmodule

// File: rtl/mskand_hpc2_arb.sv
// Round-robin arbiter feeding two requesters into one HPC2 masked AND gadget.
// Optional build macro MSKAND_ARB_IDLE_ZERO_EN: zero gadget inputs on idle stages.
module mskand_hpc2_arb
    import mskand_hpc2_arb_pkg::*;
#(
    parameter int d       = 2,
    parameter int hpc2rnd = hpc2rnd_f(d)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [d-1:0]       req_a0,
    input  logic [d-1:0]       req_b0,
    input  logic [d-1:0]       req_a1,
    input  logic [d-1:0]       req_b1,
    input  logic [hpc2rnd-1:0] rnd_in,
    input  logic               rnd_valid,
    output logic               rnd_ready,
    output logic [d-1:0]       res,
    output logic               res_valid,
    output logic               res_id,
    output logic               busy
);

    logic               issue_s;
    req_id_e            gnt_s;
    logic [d-1:0]       a_mux_s;
    logic [d-1:0]       b_mux_s;
    logic [d-1:0]       inb_s;
    logic [hpc2rnd-1:0] rnd_s;
    logic [d-1:0]       ina_q;
    logic [d-1:0]       ina_d;
    req_id_e            last_gnt_q;
    logic               v1_q;
    req_id_e            id1_q;
    logic               v2_q;
    req_id_e            id2_q;
    logic [1:0]         count_q;
    logic [1:0]         count_d;

    // Issue decision and round-robin grant selection.
    always_comb begin
        issue_s = 1'b0;
        gnt_s   = REQ_0;
        if (rst) begin
            issue_s = 1'b0;
        end else begin
            issue_s = rnd_valid & (|req_valid);
        end
        case (req_valid)
            2'b01:   gnt_s = REQ_0;
            2'b10:   gnt_s = REQ_1;
            2'b11:   gnt_s = (last_gnt_q == REQ_0) ? REQ_1 : REQ_0;
            default: gnt_s = REQ_0;
        endcase
    end

    // One select drives both operand muxes, so requesters never mix in a stage.
    assign a_mux_s   = (gnt_s == REQ_1) ? req_a1 : req_a0;
    assign b_mux_s   = (gnt_s == REQ_1) ? req_b1 : req_b0;
    assign req_ready = issue_s ? ((gnt_s == REQ_1) ? 2'b10 : 2'b01) : 2'b00;
    assign rnd_ready = issue_s;

    // Stage-0 gadget inputs (inb, rnd) and next value of the ina register.
    always_comb begin
        ina_d = ina_q;
        inb_s = b_mux_s;
        rnd_s = rnd_in;
        if (issue_s) begin
            ina_d = a_mux_s;
        end else begin
`ifdef MSKAND_ARB_IDLE_ZERO_EN
            ina_d = '0;
            inb_s = '0;
            rnd_s = '0;
`else
            ina_d = ina_q;
`endif
        end
    end

    // In-flight count: +1 per issue, -1 when an issue reaches the output stage.
    always_comb begin
        count_d = count_q;
        if (issue_s && !v2_q) begin
            count_d = count_q + 2'd1;
        end else if (!issue_s && v2_q) begin
            count_d = count_q - 2'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Valid/id shift pipeline, ina register, round-robin pointer and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ina_q      <= '0;
            last_gnt_q <= REQ_1;
            v1_q       <= 1'b0;
            id1_q      <= REQ_0;
            v2_q       <= 1'b0;
            id2_q      <= REQ_0;
            count_q    <= 2'd0;
        end else begin
            ina_q   <= ina_d;
            v1_q    <= issue_s;
            id1_q   <= gnt_s;
            v2_q    <= v1_q;
            id2_q   <= id1_q;
            count_q <= count_d;
            if (issue_s) begin
                last_gnt_q <= gnt_s;
            end else begin
                last_gnt_q <= last_gnt_q;
            end
        end
    end

    assign res_valid = v2_q;
    assign res_id    = id2_q;
    assign busy      = (count_q != 2'd0) | issue_s;

    mskand_hpc2_arb_gadget #(
        .d       (d),
        .hpc2rnd (hpc2rnd)
    ) u_gadget (
        .clk (clk),
        .rst (rst),
        .ina (ina_q),
        .inb (inb_s),
        .rnd (rnd_s),
        .res (res)
    );

endmodule

// File: tb/tb_mskand_hpc2_arb.sv
// Bench for mskand_hpc2_arb: directed table, reset corner, random model, d=3 sweep.
module tb_mskand_hpc2_arb;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [1:0] req_a0, req_b0, req_a1, req_b1;
    logic [0:0] rnd_in;
    logic       rnd_valid;
    logic       rnd_ready;
    logic [1:0] res;
    logic       res_valid;
    logic       res_id;
    logic       busy;

    logic [1:0] t3_req_valid;
    logic [1:0] t3_req_ready;
    logic [2:0] t3_a0, t3_b0, t3_a1, t3_b1;
    logic [2:0] t3_rnd_in;
    logic       t3_rnd_valid;
    logic       t3_rnd_ready;
    logic [2:0] t3_res;
    logic       t3_res_valid;
    logic       t3_res_id;
    logic       t3_busy;

    mskand_hpc2_arb #(.d(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .res(res), .res_valid(res_valid), .res_id(res_id), .busy(busy)
    );

    mskand_hpc2_arb #(.d(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(t3_req_valid), .req_ready(t3_req_ready),
        .req_a0(t3_a0), .req_b0(t3_b0), .req_a1(t3_a1), .req_b1(t3_b1),
        .rnd_in(t3_rnd_in), .rnd_valid(t3_rnd_valid), .rnd_ready(t3_rnd_ready),
        .res(t3_res), .res_valid(t3_res_valid), .res_id(t3_res_id), .busy(t3_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] rv;
        logic       rndv;
        logic [1:0] ready;
        logic       rndr;
        logic       busy;
        logic       resv;
        logic       id;
        logic       x;
    } vec_t;
    vec_t tbl[14];

    typedef struct {
        int id;
        int val;
        int age;
    } fl_t;
    fl_t q[$];

    typedef struct {
        int id;
        int val;
    } sb_t;
    sb_t sb3[$];

    int         last_g;
    logic [1:0] pend;
    int         g;
    bit         exp_issue;
    bit         busy_pre;
    int         av, bv;
    int         k3_a, k3_b, k3_r;
    sb_t        e3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] mk3(input int v);
        logic [2:0] s;
        s    = 3'($urandom_range(0, 7));
        s[0] = s[0] ^ (^s) ^ v[0];
        return s;
    endfunction

    task automatic do_reset();
        rst          = 1'b1;
        req_valid    = 2'b11;
        rnd_valid    = 1'b1;
        t3_req_valid = 2'b11;
        t3_rnd_valid = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rnd_ready", 32'(rnd_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_res", 32'(res), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ina", 32'(dut.ina_q), 32'd0);
        chk("rst_t3_res_valid", 32'(t3_res_valid), 32'd0);
        next_cycle();
        next_cycle();
        rst          = 1'b0;
        req_valid    = 2'b00;
        rnd_valid    = 1'b0;
        t3_req_valid = 2'b00;
        t3_rnd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b00; rnd_valid = 1'b0; rnd_in = 1'b0;
        req_a0 = 2'b01; req_b0 = 2'b10; req_a1 = 2'b11; req_b1 = 2'b01;
        t3_req_valid = 2'b00; t3_rnd_valid = 1'b0; t3_rnd_in = 3'd0;
        t3_a0 = 3'd0; t3_b0 = 3'd0; t3_a1 = 3'd0; t3_b1 = 3'd0;

        // rv, rndv, ready, rndr, busy, resv, id, xor(res)
        tbl[0]  = '{2'b11, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{2'b11, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[13] = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        do_reset();

        // Directed table: contention, drain, randomness stall, single requester.
        for (int k = 0; k < 14; k++) begin
            req_valid = tbl[k].rv;
            rnd_valid = tbl[k].rndv;
            rnd_in    = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", k), 32'(req_ready), 32'(tbl[k].ready));
            chk($sformatf("tbl%0d_rnd_ready", k), 32'(rnd_ready), 32'(tbl[k].rndr));
            chk($sformatf("tbl%0d_busy", k), 32'(busy), 32'(tbl[k].busy));
            chk($sformatf("tbl%0d_res_valid", k), 32'(res_valid), 32'(tbl[k].resv));
            if (tbl[k].resv) begin
                chk($sformatf("tbl%0d_res_id", k), 32'(res_id), 32'(tbl[k].id));
                chk($sformatf("tbl%0d_res_xor", k), 32'(^res), 32'(tbl[k].x));
            end
            next_cycle();
        end

        // Reset mid-flight: issue for requester 0, reset next cycle, nothing emerges.
        req_valid = 2'b01;
        rnd_valid = 1'b1;
        @(negedge clk);
        chk("mf_issue", 32'(req_ready), 32'd1);
        next_cycle();
        rst       = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("mf_busy_rst", 32'(busy), 32'd0);
        chk("mf_res_valid_rst", 32'(res_valid), 32'd0);
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("mf_res_valid_t%0d", c + 2), 32'(res_valid), 32'd0);
            chk($sformatf("mf_busy_t%0d", c + 2), 32'(busy), 32'd0);
            next_cycle();
        end
        req_valid = 2'b11;
        @(negedge clk);
        chk("mf_rr_after_reset", 32'(req_ready), 32'd1);
        next_cycle();
        req_valid = 2'b00;
        rnd_valid = 1'b0;
        next_cycle();

        // Random traffic against a transaction-level reference model.
        do_reset();
        last_g = 1;
        pend   = 2'b00;
        q.delete();
        for (int c = 0; c < 400; c++) begin
            foreach (q[i]) q[i].age++;
            while (q.size() > 0 && q[0].age > 2) void'(q.pop_front());
            busy_pre = (q.size() > 0);
            if (!pend[0]) begin
                pend[0] = 1'($urandom_range(0, 1));
                req_a0  = 2'($urandom_range(0, 3));
                req_b0  = 2'($urandom_range(0, 3));
            end
            if (!pend[1]) begin
                pend[1] = 1'($urandom_range(0, 1));
                req_a1  = 2'($urandom_range(0, 3));
                req_b1  = 2'($urandom_range(0, 3));
            end
            req_valid = pend;
            rnd_valid = (c < 394) && ($urandom_range(0, 3) != 0);
            rnd_in    = 1'($urandom_range(0, 1));
            exp_issue = rnd_valid && (pend != 2'b00);
            g = 0;
            if (exp_issue) begin
                if (pend == 2'b11) g = 1 - last_g;
                else g = pend[1] ? 1 : 0;
                av = (g == 1) ? int'(^req_a1) : int'(^req_a0);
                bv = (g == 1) ? int'(^req_b1) : int'(^req_b0);
                q.push_back('{g, av & bv, 0});
                last_g = g;
            end
            @(negedge clk);
            chk("rnd_ready_grant", 32'(req_ready), exp_issue ? 32'(1 << g) : 32'd0);
            chk("rnd_rnd_ready", 32'(rnd_ready), 32'(exp_issue));
            chk("rnd_busy", 32'(busy), 32'(busy_pre || exp_issue));
            chk("rnd_res_valid", 32'(res_valid), 32'(q.size() > 0 && q[0].age == 2));
            if (q.size() > 0 && q[0].age == 2) begin
                chk("rnd_res_id", 32'(res_id), 32'(q[0].id));
                chk("rnd_res_xor", 32'(^res), 32'(q[0].val));
            end
            if (exp_issue) pend[g] = 1'b0;
            next_cycle();
        end
        req_valid = 2'b00;
        rnd_valid = 1'b0;

        // d=3 sweep: every (a, b, requester) with random shares and randomness.
        sb3.delete();
        for (int k = 0; k < 40; k++) begin
            t3_req_valid = 2'b00;
            t3_rnd_valid = 1'b0;
            if (k < 32) begin
                k3_a = k & 1;
                k3_b = (k >> 1) & 1;
                k3_r = (k >> 2) & 1;
                t3_rnd_valid = 1'b1;
                t3_rnd_in    = 3'($urandom_range(0, 7));
                if (k3_r == 0) begin
                    t3_a0 = mk3(k3_a); t3_b0 = mk3(k3_b);
                    t3_a1 = 3'($urandom_range(0, 7)); t3_b1 = 3'($urandom_range(0, 7));
                    t3_req_valid = 2'b01;
                end else begin
                    t3_a1 = mk3(k3_a); t3_b1 = mk3(k3_b);
                    t3_a0 = 3'($urandom_range(0, 7)); t3_b0 = 3'($urandom_range(0, 7));
                    t3_req_valid = 2'b10;
                end
                sb3.push_back('{k3_r, k3_a & k3_b});
            end
            @(negedge clk);
            chk("d3_rnd_ready", 32'(t3_rnd_ready), 32'(k < 32));
            if (t3_res_valid) begin
                if (sb3.size() == 0) begin
                    chk("d3_unexpected_res", 32'd1, 32'd0);
                end else begin
                    e3 = sb3.pop_front();
                    chk("d3_res_id", 32'(t3_res_id), 32'(e3.id));
                    chk("d3_res_xor", 32'(^t3_res), 32'(e3.val));
                end
            end
            next_cycle();
        end
        chk("d3_outstanding", 32'(sb3.size()), 32'd0);

`ifdef MSKAND_ARB_IDLE_ZERO_EN
        // Idle stages drive zero into the gadget.
        req_valid = 2'b00;
        rnd_valid = 1'b1;
        req_b0    = 2'b11;
        rnd_in    = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("idle_ina", 32'(dut.ina_q), 32'd0);
        chk("idle_inb", 32'(dut.inb_s), 32'd0);
        chk("idle_rnd", 32'(dut.rnd_s), 32'd0);
        next_cycle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mskand_hpc2_arb.md
MSKAND_HPC2_ARB -- requirements
Module: mskand_hpc2_arb

Interface
REQ-001 SHALL have parameter d, default 2, giving the number of shares per sharing.
REQ-002 SHALL have parameter hpc2rnd, default d*(d-1)/2, giving the fresh random bits consumed per gadget issue.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  2  per-requester operand-pair valid.
REQ-006 SHALL have port req_ready  output  2  per-requester grant; one-hot or zero.
REQ-007 SHALL have ports req_a0, req_b0, req_a1, req_b1  input  d each  operand sharings of requesters 0 and 1.
REQ-008 SHALL have port rnd_in  input  hpc2rnd  fresh randomness.
REQ-009 SHALL have port rnd_valid  input  1  randomness available.
REQ-010 SHALL have port rnd_ready  output  1  randomness consumed this cycle.
REQ-011 SHALL have port res  output  d  product sharing.
REQ-012 SHALL have port res_valid  output  1  res valid this cycle.
REQ-013 SHALL have port res_id  output  1  requester index owning res.
REQ-014 SHALL have port busy  output  1  high while any issue is in flight.

Function
REQ-015 SHALL issue in cycle T only when rnd_valid=1 and at least one req_valid bit is 1; issue asserts req_ready[g] and rnd_ready in T, both combinational from the current inputs and state.
REQ-016 SHALL arbitrate round-robin: if only one requester is valid, grant it; if both are valid, grant the requester not granted at the last issue.
REQ-017 SHALL drive the gadget in T with inb = req_b[g] and rnd = rnd_in.
REQ-018 SHALL register req_a[g] in T and drive the gadget ina from that register in T+1, matching the gadget ina latency of 1.
REQ-019 SHALL assert res_valid with res_id=g in T+2, with res equal to the gadget output; XOR of res shares = (XOR a shares) AND (XOR b shares).
REQ-020 SHALL sustain back-to-back issues, one per cycle, with no bubbles while rnd_valid and a req_valid remain high.
REQ-021 SHALL NOT issue when rnd_valid=0; req_ready and rnd_ready are 0, and the pipeline drains normally.
REQ-022 SHALL track the in-flight issue count (0..2) with a 2-bit counter; busy=1 iff count>0 or an issue occurs this cycle.
REQ-023 SHALL apply no output backpressure; the consumer accepts res whenever res_valid=1.
REQ-024 SHALL keep each requester's operands and valid unchanged until granted; the block makes no check of this.
REQ-025 SHALL never drive a share of one requester into the same gadget cycle as a share of the other (single mux select per issue stage).

Reset
REQ-026 SHALL, while rst=1, force req_ready=0, rnd_ready=0, res_valid=0, res_id=0, res=0, busy=0, count=0, ina register=0, and the round-robin pointer to favour requester 0.
REQ-027 SHALL discard in-flight issues on reset mid-operation; no res_valid is produced for them after rst deasserts.

Configuration
REQ-028 SHALL support macro MSKAND_ARB_IDLE_ZERO_EN; when defined, gadget ina, inb and rnd are driven to 0 in any stage with no valid issue.
REQ-029 SHALL, without MSKAND_ARB_IDLE_ZERO_EN, hold the gadget inputs at their last mux values on idle stages (lower area).
REQ-030 SHALL make res_valid and res functionally identical in both builds for valid issues.

Structure
REQ-031 SHALL take the constant hpc2rnd and the requester-count localparam (2) from the shared masked-gadget header/package.
REQ-032 SHALL instantiate exactly one existing HPC2 masked AND gadget (ina latency 1, inb latency 0, output latency 2) as its sole sub-module.
REQ-033 SHALL keep the arbitration, valid/id 2-stage shift pipeline and counter in the top module.

Verification
REQ-034 SHALL cover single requester, d=2: req_a0=01, req_b0=10, rnd_valid=1 at T -> req_ready=01 at T; res_valid=1, res_id=0 at T+2, XOR(res)=1.
REQ-035 SHALL cover contention: both valid for 4 cycles, rnd_valid=1 -> grants 0,1,0,1; res_id 0,1,0,1 from T+2; busy=1 throughout.
REQ-036 SHALL cover randomness stall: rnd_valid=0 for 3 cycles with req_valid=01 -> no grant and rnd_ready=0; issue in the first cycle rnd_valid=1.
REQ-037 SHALL cover reset mid-flight: issue at T, rst=1 at T+1 -> res_valid stays 0 through T+4, busy=0, and the next contended grant goes to requester 0.
REQ-038 SHALL cover an exhaustive functional check, d=2 and d=3: all operand values with random shares and randomness -> XOR(res) = a AND b for every issue.
REQ-039 SHALL cover the idle-zero build with MSKAND_ARB_IDLE_ZERO_EN: on an idle cycle, probed gadget ina, inb and rnd = 0.
